// File: rtl/register_file_mp.sv
// Two-write/two-read register file with per-entry valid bits, synchronous clear,
// optional same-cycle write forwarding and optional registered read ports.
module register_file_mp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_REG = 0,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en_1,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              wr_en_2,
    input  logic [ADDR_W-1:0] wr_addr_2,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] data_out_a,
    output logic              valid_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_b,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_a;
    logic              rd_valid_b;

    // Port 2 is written after port 1 so it wins when both hit the same entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid     <= '0;
            collision <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid     <= '0;
            collision <= 1'b0;
        end else begin
            if (wr_en_1) begin
                mem[wr_addr_1]   <= data_in_1;
                valid[wr_addr_1] <= 1'b1;
            end
            if (wr_en_2) begin
                mem[wr_addr_2]   <= data_in_2;
                valid[wr_addr_2] <= 1'b1;
            end
            collision <= wr_en_1 && wr_en_2 && (wr_addr_1 == wr_addr_2);
        end
    end

    // A pending clear suppresses forwarding so readers see the stored value.
    always_comb begin
        rd_data_a  = mem[rd_addr_a];
        rd_valid_a = valid[rd_addr_a];
        if (BYPASS != 0 && !clr) begin
            if (wr_en_1 && wr_addr_1 == rd_addr_a) begin
                rd_data_a  = data_in_1;
                rd_valid_a = 1'b1;
            end
            if (wr_en_2 && wr_addr_2 == rd_addr_a) begin
                rd_data_a  = data_in_2;
                rd_valid_a = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_b  = mem[rd_addr_b];
        rd_valid_b = valid[rd_addr_b];
        if (BYPASS != 0 && !clr) begin
            if (wr_en_1 && wr_addr_1 == rd_addr_b) begin
                rd_data_b  = data_in_1;
                rd_valid_b = 1'b1;
            end
            if (wr_en_2 && wr_addr_2 == rd_addr_b) begin
                rd_data_b  = data_in_2;
                rd_valid_b = 1'b1;
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_out_a <= '0;
                    data_out_b <= '0;
                    valid_a    <= 1'b0;
                    valid_b    <= 1'b0;
                end else begin
                    data_out_a <= rd_data_a;
                    data_out_b <= rd_data_b;
                    valid_a    <= rd_valid_a;
                    valid_b    <= rd_valid_b;
                end
            end
        end else begin : g_rd_comb
            assign data_out_a = rd_data_a;
            assign data_out_b = rd_data_b;
            assign valid_a    = rd_valid_a;
            assign valid_b    = rd_valid_b;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: three register_file_mp variants (comb+bypass, comb no bypass,
// registered+bypass) share one stimulus stream and are checked against hand values.
module tb_register_file_mp;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       wr_en_1;
    logic [3:0] wr_addr_1;
    logic [7:0] data_in_1;
    logic       wr_en_2;
    logic [3:0] wr_addr_2;
    logic [7:0] data_in_2;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;

    logic [7:0] dout_a [3];
    logic [7:0] dout_b [3];
    logic       vld_a  [3];
    logic       vld_b  [3];
    logic       coll   [3];

    int check_count;
    int error_count;

    logic [7:0] exp_lo;
    logic [7:0] exp_hi;

    register_file_mp #(.DATA_W(8), .ADDR_W(4), .RD_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .data_in_1(data_in_1),
        .wr_en_2(wr_en_2), .wr_addr_2(wr_addr_2), .data_in_2(data_in_2),
        .rd_addr_a(rd_addr_a), .data_out_a(dout_a[0]), .valid_a(vld_a[0]),
        .rd_addr_b(rd_addr_b), .data_out_b(dout_b[0]), .valid_b(vld_b[0]),
        .collision(coll[0])
    );

    register_file_mp #(.DATA_W(8), .ADDR_W(4), .RD_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .data_in_1(data_in_1),
        .wr_en_2(wr_en_2), .wr_addr_2(wr_addr_2), .data_in_2(data_in_2),
        .rd_addr_a(rd_addr_a), .data_out_a(dout_a[1]), .valid_a(vld_a[1]),
        .rd_addr_b(rd_addr_b), .data_out_b(dout_b[1]), .valid_b(vld_b[1]),
        .collision(coll[1])
    );

    register_file_mp #(.DATA_W(8), .ADDR_W(4), .RD_REG(1), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .data_in_1(data_in_1),
        .wr_en_2(wr_en_2), .wr_addr_2(wr_addr_2), .data_in_2(data_in_2),
        .rd_addr_a(rd_addr_a), .data_out_a(dout_a[2]), .valid_a(vld_a[2]),
        .rd_addr_b(rd_addr_b), .data_out_b(dout_b[2]), .valid_b(vld_b[2]),
        .collision(coll[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w1, input logic [3:0] a1,
                                 input logic [7:0] d1, input logic w2,
                                 input logic [3:0] a2, input logic [7:0] d2);
        clr       = c;
        wr_en_1   = w1;
        wr_addr_1 = a1;
        data_in_1 = d1;
        wr_en_2   = w2;
        wr_addr_2 = a2;
        data_in_2 = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        checkOutput("rst_coll0", coll[0], 0);
        checkOutput("rst_reg_da", dout_a[2], 0);
        checkOutput("rst_reg_va", vld_a[2], 0);

        // Dirty two entries, then reset asynchronously mid-cycle.
        applyStimulus(0, 1, 0, 8'hAB, 1, 4'd15, 8'hCD);
        rd_addr_b = 4'd15;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pre_rst_da", dout_a[0], 8'hAB);
        checkOutput("pre_rst_reg_db", dout_b[2], 8'hCD);
        #3 rst = 1'b0;
        #1;
        checkOutput("async_rst_da", dout_a[0], 8'h00);
        checkOutput("async_rst_va", vld_a[0], 0);
        checkOutput("async_rst_db", dout_b[0], 8'h00);
        checkOutput("async_rst_reg_db", dout_b[2], 8'h00);
        checkOutput("async_rst_reg_vb", vld_b[2], 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = i[3:0];
            rd_addr_b = 4'(15 - i);
            #1;
            checkOutput("sweep_rst_da", dout_a[0], 8'h00);
            checkOutput("sweep_rst_va", vld_a[0], 0);
            checkOutput("sweep_rst_vb", vld_b[1], 0);
        end

        // Dual-port fill of both halves.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp_lo = 8'h01 << i;
            exp_hi = 8'hFF << i;
            applyStimulus(0, 1, i[3:0], exp_lo, 1, 4'(8 + i), exp_hi);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            exp_lo = 8'h01 << i;
            exp_hi = 8'hFF << i;
            rd_addr_a = i[3:0];
            rd_addr_b = 4'(8 + i);
            #1;
            checkOutput("fill_da", dout_a[0], exp_lo);
            checkOutput("fill_va", vld_a[0], 1);
            checkOutput("fill_db", dout_b[0], exp_hi);
            checkOutput("fill_vb", vld_b[0], 1);
            checkOutput("fill_nb_da", dout_a[1], exp_lo);
            checkOutput("fill_nb_db", dout_b[1], exp_hi);
            tick();
            checkOutput("fill_reg_da", dout_a[2], exp_lo);
            checkOutput("fill_reg_va", vld_a[2], 1);
            checkOutput("fill_reg_db", dout_b[2], exp_hi);
            checkOutput("fill_reg_vb", vld_b[2], 1);
        end

        // Registered port lags by exactly one edge.
        rd_addr_a = 4'd2;
        #1;
        checkOutput("reg_lag_old", dout_a[2], 8'h80);
        tick();
        checkOutput("reg_lag_new", dout_a[2], 8'h04);

        // Enable low leaves the entry untouched.
        applyStimulus(0, 0, 4'd1, 8'h11, 0, 0, 0);
        rd_addr_a = 4'd1;
        tick();
        checkOutput("en_low_da", dout_a[0], 8'h02);

        // Same-address collision: port 2 wins.
        applyStimulus(0, 1, 4'd3, 8'hAA, 1, 4'd3, 8'h55);
        rd_addr_a = 4'd3;
        #1;
        checkOutput("coll_fwd_da", dout_a[0], 8'h55);
        checkOutput("coll_nb_old", dout_a[1], 8'h08);
        checkOutput("coll_before", coll[0], 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("coll_high", coll[0], 1);
        checkOutput("coll_data", dout_a[1], 8'h55);
        checkOutput("coll_reg_da", dout_a[2], 8'h55);
        tick();
        checkOutput("coll_low", coll[0], 0);

        // Back-to-back collisions keep the flag high.
        applyStimulus(0, 1, 4'd4, 8'h01, 1, 4'd4, 8'h02);
        tick();
        applyStimulus(0, 1, 4'd6, 8'h03, 1, 4'd6, 8'h04);
        tick();
        checkOutput("coll_b2b", coll[0], 1);
        applyStimulus(0, 1, 4'd6, 8'h40, 1, 4'd7, 8'h80);
        tick();
        checkOutput("coll_diff_addr", coll[0], 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rd_addr_a = 4'd4;
        rd_addr_b = 4'd6;
        #1;
        checkOutput("b2b_a4", dout_a[0], 8'h02);
        checkOutput("b2b_b6", dout_b[0], 8'h40);

        // Forwarding of a port 1 write.
        applyStimulus(0, 1, 4'd5, 8'h3C, 0, 0, 0);
        rd_addr_a = 4'd5;
        #1;
        checkOutput("fwd_da", dout_a[0], 8'h3C);
        checkOutput("fwd_va", vld_a[0], 1);
        checkOutput("nofwd_da", dout_a[1], 8'h20);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("nofwd_after", dout_a[1], 8'h3C);
        checkOutput("fwd_reg_da", dout_a[2], 8'h3C);

        // Clear beats both writes and suppresses forwarding and collision.
        applyStimulus(1, 1, 4'd9, 8'h66, 1, 4'd9, 8'h77);
        rd_addr_a = 4'd9;
        #1;
        checkOutput("clr_nofwd_da", dout_a[0], 8'hFE);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("clr_coll", coll[0], 0);
        checkOutput("clr_a9", dout_a[0], 8'h00);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = i[3:0];
            rd_addr_b = i[3:0];
            #1;
            checkOutput("clr_da", dout_a[0], 8'h00);
            checkOutput("clr_va", vld_a[0], 0);
            checkOutput("clr_vb", vld_b[0], 0);
            checkOutput("clr_nb_db", dout_b[1], 8'h00);
        end
        tick();
        checkOutput("clr_reg_da", dout_a[2], 8'h00);
        checkOutput("clr_reg_va", vld_a[2], 0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised two-write/two-read register file, the successor to the 16-entry dual-write-port register file. Both write ports address the full array instead of fixed halves. Two independent read ports can be combinational or registered, with optional write-to-read forwarding. Adds per-entry valid tracking, a synchronous bulk clear, and a write-collision flag, for use as the general-purpose register bank in datapath labs.

## Interface
- DATA_W, 8: width of each entry and every data port.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- RD_REG, 0: 0 = combinational read ports; 1 = read data and valid registered, 1-cycle latency.
- BYPASS, 1: 1 = a read of an address being written this cycle returns the incoming write data; 0 = returns stored (old) contents.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of all entries and valid bits.
- wr_en_1  input  1  write enable, port 1.
- wr_addr_1  input  ADDR_W  write address, port 1.
- data_in_1  input  DATA_W  write data, port 1.
- wr_en_2  input  1  write enable, port 2.
- wr_addr_2  input  ADDR_W  write address, port 2.
- data_in_2  input  DATA_W  write data, port 2.
- rd_addr_a  input  ADDR_W  read address, port A.
- data_out_a  output  DATA_W  read data, port A.
- valid_a  output  1  entry at rd_addr_a has been written since the last reset or clear.
- rd_addr_b  input  ADDR_W  read address, port B.
- data_out_b  output  DATA_W  read data, port B.
- valid_b  output  1  valid bit for port B.
- collision  output  1  registered; high for one cycle after both ports wrote the same address.

## Operation
- Storage: DEPTH x DATA_W entries plus a DEPTH-bit valid vector.
- Write: on a rising edge with wr_en_n = 1 and clr = 0:
  - entry[wr_addr_n] is loaded with data_in_n;
  - valid[wr_addr_n] is set.
- Both ports enabled, different addresses: both writes take effect on the same edge.
- Both ports enabled, same address: port 2 wins, port 1 data is dropped, and collision = 1 on the next cycle.
- Clear: clr = 1 at a rising edge zeroes all entries and valid bits.
  - clr has priority over both writes on that edge; the writes are discarded.
  - collision is forced to 0 on that edge.
- Read: each port independently returns entry[rd_addr] and valid[rd_addr].
  - Port A and port B may use the same address.
  - Reads have no side effects.
- Forwarding (BYPASS = 1): if rd_addr matches an enabled write address in the same cycle, the read returns that write data with valid = 1.
  - If both write ports match, port 2's data is returned.
  - If clr = 1 in that cycle, no forwarding occurs and the stored value is returned.
- No forwarding (BYPASS = 0): reads always return stored contents.
- Reset: asserting rst (0) immediately, independent of clk:
  - zeroes all entries and the valid vector;
  - drives collision to 0;
  - with RD_REG = 1, zeroes the registered data_out and valid outputs.
  - The block holds this state while rst = 0.

## Timing
- Write latency, no forwarding: data written at edge k is readable on combinational ports after edge k.
- RD_REG = 0, BYPASS = 1: data_out follows rd_addr and the same-cycle write combinationally.
- RD_REG = 1: data_out and valid reflect the address presented before edge k and are updated at edge k.
  - With BYPASS = 1, a same-edge write is forwarded into the registered output.
  - With BYPASS = 0, the pre-write value is captured.
- Reset values:
  - collision = 0.
  - RD_REG = 1: data_out_a, data_out_b, valid_a and valid_b = 0.
  - RD_REG = 0: all outputs read 0 because the storage is zeroed.
- collision is asserted for exactly one cycle per colliding edge; back-to-back collisions keep it high continuously.
- Reset mid-operation: a write on the edge coincident with or after rst falling is lost. The first write accepted is on the first rising edge with rst = 1.
- Address wrap: all ADDR_W codes are valid entries, so no out-of-range case exists.

## Test plan
- Reset then read all: after rst pulses low for 2 ns mid-cycle, both ports sweep 0..15 and read 8'h00 with valid = 0. Change is asynchronous, before the next edge.
- Dual-port fill: over 8 cycles, port 1 writes 8'h01<<i to addr i (0–7) while port 2 writes 8'hFF<<i to addr 8+i. Ports A and B then read back every entry with valid = 1.
- Collision: both ports write addr 3, with data 8'hAA on port 1 and 8'h55 on port 2.
  - Read of addr 3 returns 8'h55.
  - collision = 1 for exactly one cycle, then 0.
- Enable low: write 8'h11 to addr 1 with wr_en_1 = 0; addr 1 still holds its prior value 8'h02.
- Forwarding: BYPASS = 1, RD_REG = 0. rd_addr_a = 5 while port 1 writes 8'h3C to addr 5, and data_out_a = 8'h3C in the same cycle.
  - With BYPASS = 0, data_out_a shows the old value until after the edge.
- Clear priority: clr = 1 on the same edge as port 2 writes 8'h77 to addr 9.
  - All entries read 8'h00 with valid = 0.
  - Addr 9 does not hold 8'h77.
  - collision = 0.
- RD_REG = 1 variant: repeat the fill and readback; each read appears exactly one edge after its address is presented.
